slavefifo2b_streamin: RTL and testbench
=======================================

SLAVEFIFO2B_STREAMIN -- requirements
Module: slavefifo2b_streamin

Interface
REQ-001 Parameter WR_DELAY_CYCLES, default 1: number of extra write cycles after flagb_d falls (range 1-3).
REQ-002 Parameter SHORT_PKT_WORDS, default 0: burst length in words that ends with a PKTEND strobe; 0 disables short packets.
REQ-003 clk_100  input  1  100 MHz clock; every register updates on its rising edge.
REQ-004 reset_  input  1  asynchronous, active-low reset.
REQ-005 stream_in_mode_selected  input  1  enables stream-IN (FPGA to FX3) mode.
REQ-006 flaga_d  input  1  registered FLAGA, high = write-thread DMA buffer ready.
REQ-007 flagb_d  input  1  registered FLAGB, low = write-thread watermark reached (almost full).
REQ-008 slwr_streamin_  output  1  active-low slave FIFO write strobe.
REQ-009 pktend_streamin_  output  1  active-low packet-end strobe.
REQ-010 streamin_wr_select_slavefifo_addr  output  1  high while the block owns the write-thread address.
REQ-011 data_out_stream_in  output  32  write data to the FX3 data bus.

Function
REQ-012 FSM states: IDLE, WAIT_FLAGA, WAIT_FLAGB, WRITE, WR_DELAY.
REQ-013 IDLE: stream_in_mode_selected=1 -> WAIT_FLAGA; otherwise stay in IDLE.
REQ-014 WAIT_FLAGA: flaga_d=1 -> WAIT_FLAGB; otherwise stay.
REQ-015 WAIT_FLAGB: flagb_d=1 -> WRITE and clear burst_cnt to 0; otherwise stay.
REQ-016 WRITE, priority 1: SHORT_PKT_WORDS!=0 and burst_cnt==SHORT_PKT_WORDS-1 -> WAIT_FLAGA.
REQ-017 WRITE, priority 2: flagb_d=0 -> WR_DELAY and load dly_cnt with WR_DELAY_CYCLES-1.
REQ-018 WRITE: otherwise stay in WRITE and increment burst_cnt (16-bit, saturating).
REQ-019 WR_DELAY: dly_cnt==0 -> WAIT_FLAGA; otherwise decrement dly_cnt and stay.
REQ-020 In any non-IDLE state, stream_in_mode_selected=0 forces next state IDLE; this overrides REQ-013 to REQ-019.
REQ-021 slwr_streamin_ = 0 exactly when the state is WRITE or WR_DELAY (combinational decode of the state register).
REQ-022 pktend_streamin_ = 0 for exactly one cycle: in WRITE when the REQ-016 condition holds, coincident with the last slwr_streamin_ low cycle.
REQ-023 streamin_wr_select_slavefifo_addr = 1 in every state except IDLE.
REQ-024 data_out_stream_in = data_cnt at all times.
REQ-025 data_cnt is a 32-bit counter that increments by 1 at each clock edge where slwr_streamin_=0, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-026 Write count per burst with no short packet = (number of WRITE cycles) + WR_DELAY_CYCLES.
REQ-027 data_cnt clears to 0 on the first clock edge in IDLE while stream_in_mode_selected=0; it is held across bursts while the mode stays selected.
REQ-028 A deassertion of flaga_d during WRITE or WR_DELAY has no effect; only flagb_d and the packet count end a burst.
REQ-029 When flagb_d=0 and the short-packet condition occur together, pktend (REQ-016) wins and WR_DELAY is skipped.

Reset
REQ-030 While reset_=0: state=IDLE, data_cnt=0, burst_cnt=0, dly_cnt=0.
REQ-031 While reset_=0: slwr_streamin_=1, pktend_streamin_=1, streamin_wr_select_slavefifo_addr=0, data_out_stream_in=0x00000000.
REQ-032 Reset asserted mid-burst immediately (asynchronously) deasserts slwr_streamin_ and pktend_streamin_.
REQ-033 The first write after reset release carries data 0x00000000.

Verification
REQ-034 Defaults, mode=1, flaga=1, flagb=1 for 10 WRITE cycles, then flagb=0 -> 11 writes with data 0..10, then state WAIT_FLAGA, slwr_ high.
REQ-035 SHORT_PKT_WORDS=4, flags held high -> slwr_ low 4 cycles with data 0..3, pktend_ low on the 4th cycle only; next burst starts at data 4.
REQ-036 WR_DELAY_CYCLES=3, flagb falls after 5 WRITE cycles -> exactly 8 writes, then WAIT_FLAGA.
REQ-037 Mode dropped during WRITE -> slwr_ high on the next cycle, state IDLE, data_cnt=0 one cycle later, select output 0.
REQ-038 data_cnt forced near wrap (start 0xFFFFFFFE), 3 writes -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-039 reset_ pulsed low mid-WRITE asynchronously -> outputs at REQ-031 values immediately; first write after release carries data 0.

Source files
------------

// File: rtl/slavefifo2b_streamin.sv
// rtl/slavefifo2b_streamin.sv - FX3 slave FIFO stream-IN (FPGA to FX3) write sequencer
//
// Purpose:
//   Waits for the FX3 write-thread buffer to become ready, then bursts an
//   incrementing 32-bit pattern into the slave FIFO. A burst ends either on
//   the almost-full watermark (flagb_d low) followed by a few drain writes,
//   or on a short packet of SHORT_PKT_WORDS words closed with a PKTEND strobe.
//
// Ports:
//   clk_100                            in   1   100 MHz clock
//   reset_                             in   1   asynchronous active-low reset
//   stream_in_mode_selected            in   1   enables stream-IN mode
//   flaga_d                            in   1   registered FLAGA, 1 = DMA buffer ready
//   flagb_d                            in   1   registered FLAGB, 0 = watermark reached
//   slwr_streamin_                     out  1   active-low write strobe
//   pktend_streamin_                   out  1   active-low packet-end strobe
//   streamin_wr_select_slavefifo_addr  out  1   high while this block owns the address
//   data_out_stream_in                 out  32  write data

module slavefifo2b_streamin #(
    parameter int WR_DELAY_CYCLES = 1,
    parameter int SHORT_PKT_WORDS = 0
) (
    input  logic        clk_100,
    input  logic        reset_,
    input  logic        stream_in_mode_selected,
    input  logic        flaga_d,
    input  logic        flagb_d,
    output logic        slwr_streamin_,
    output logic        pktend_streamin_,
    output logic        streamin_wr_select_slavefifo_addr,
    output logic [31:0] data_out_stream_in
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FLAGA = 3'd1,
        WAIT_FLAGB = 3'd2,
        WRITE      = 3'd3,
        WR_DELAY   = 3'd4
    } state_t;

    localparam bit          SHORT_EN   = (SHORT_PKT_WORDS != 0);
    localparam logic [15:0] SHORT_LAST = SHORT_EN ? 16'(SHORT_PKT_WORDS - 1) : 16'd0;
    localparam logic [1:0]  DLY_LOAD   = 2'(WR_DELAY_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_data_cnt;
    logic [15:0] r_burst_cnt;
    logic [15:0] w_burst_nxt;
    logic [1:0]  r_dly_cnt;
    logic [1:0]  w_dly_nxt;
    logic        w_short_last;
    logic        w_writing;

    assign w_short_last = SHORT_EN && (r_burst_cnt == SHORT_LAST);
    assign w_writing    = (r_state == WRITE) || (r_state == WR_DELAY);

    // Outputs decode the state register only, so an asynchronous reset
    // releases the strobes without waiting for a clock edge.
    assign slwr_streamin_                    = !w_writing;
    assign pktend_streamin_                  = !((r_state == WRITE) && w_short_last);
    assign streamin_wr_select_slavefifo_addr = (r_state != IDLE);
    assign data_out_stream_in                = r_data_cnt;

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_state     <= IDLE;
            r_burst_cnt <= 16'd0;
            r_dly_cnt   <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_dly_cnt   <= w_dly_nxt;
        end
    end

    // Data pattern persists across bursts; it only restarts once the mode
    // has been dropped and the block is back in IDLE.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_data_cnt <= 32'd0;
        end else if (w_writing) begin
            r_data_cnt <= r_data_cnt + 32'd1;
        end else if ((r_state == IDLE) && !stream_in_mode_selected) begin
            r_data_cnt <= 32'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_dly_nxt   = r_dly_cnt;
        case (r_state)
            IDLE: begin
                if (stream_in_mode_selected) w_state_nxt = WAIT_FLAGA;
            end
            WAIT_FLAGA: begin
                if (flaga_d) w_state_nxt = WAIT_FLAGB;
            end
            WAIT_FLAGB: begin
                if (flagb_d) begin
                    w_state_nxt = WRITE;
                    w_burst_nxt = 16'd0;
                end
            end
            WRITE: begin
                // Short packet beats the watermark: the PKTEND write closes
                // the buffer, so no drain writes follow.
                if (w_short_last) begin
                    w_state_nxt = WAIT_FLAGA;
                end else if (!flagb_d) begin
                    w_state_nxt = WR_DELAY;
                    w_dly_nxt   = DLY_LOAD;
                end else if (r_burst_cnt != 16'hFFFF) begin
                    w_burst_nxt = r_burst_cnt + 16'd1;
                end
            end
            WR_DELAY: begin
                if (r_dly_cnt == 2'd0) w_state_nxt = WAIT_FLAGA;
                else                   w_dly_nxt   = r_dly_cnt - 2'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if ((r_state != IDLE) && !stream_in_mode_selected) w_state_nxt = IDLE;
    end

endmodule

// File: tb/tb_slavefifo2b_streamin.sv
// tb/tb_slavefifo2b_streamin.sv - directed self-checking bench for slavefifo2b_streamin

module tb_slavefifo2b_streamin;

    logic clk_100 = 1'b0;
    logic reset_  = 1'b1;
    always #5 clk_100 = ~clk_100;

    // dut0: defaults, dut1: SHORT_PKT_WORDS=4, dut2: WR_DELAY_CYCLES=3
    logic        m0 = 0, fa0 = 0, fb0 = 0;
    logic        m1 = 0, fa1 = 0, fb1 = 0;
    logic        m2 = 0, fa2 = 0, fb2 = 0;
    logic        slwr0, pkt0, sel0;
    logic        slwr1, pkt1, sel1;
    logic        slwr2, pkt2, sel2;
    logic [31:0] d0, d1, d2;

    slavefifo2b_streamin dut0 (
        .clk_100(clk_100), .reset_(reset_), .stream_in_mode_selected(m0),
        .flaga_d(fa0), .flagb_d(fb0), .slwr_streamin_(slwr0), .pktend_streamin_(pkt0),
        .streamin_wr_select_slavefifo_addr(sel0), .data_out_stream_in(d0));

    slavefifo2b_streamin #(.SHORT_PKT_WORDS(4)) dut1 (
        .clk_100(clk_100), .reset_(reset_), .stream_in_mode_selected(m1),
        .flaga_d(fa1), .flagb_d(fb1), .slwr_streamin_(slwr1), .pktend_streamin_(pkt1),
        .streamin_wr_select_slavefifo_addr(sel1), .data_out_stream_in(d1));

    slavefifo2b_streamin #(.WR_DELAY_CYCLES(3)) dut2 (
        .clk_100(clk_100), .reset_(reset_), .stream_in_mode_selected(m2),
        .flaga_d(fa2), .flagb_d(fb2), .slwr_streamin_(slwr2), .pktend_streamin_(pkt2),
        .streamin_wr_select_slavefifo_addr(sel2), .data_out_stream_in(d2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    int          n;
    logic [31:0] exp_d;

    initial begin
        #1 reset_ = 1'b0;
        @(negedge clk_100);
        check("rst_slwr",   32'(slwr0), 32'd1);
        check("rst_pktend", 32'(pkt0),  32'd1);
        check("rst_sel",    32'(sel0),  32'd0);
        check("rst_data",   d0,         32'd0);
        check("rst_state",  32'(dut0.r_state), 32'd0);
        @(negedge clk_100);
        reset_ = 1'b1;

        // Watermark-terminated burst, default delay: 10 WRITE + 1 drain
        m0 = 1; fa0 = 1; fb0 = 1;
        for (int k = 0; k < 20 && slwr0; k++) @(negedge clk_100);
        check("t1_start", 32'(slwr0), 32'd0);
        n = 0; exp_d = 0;
        while (!slwr0 && n < 40) begin
            check($sformatf("t1_d%0d", n), d0, exp_d);
            exp_d++;
            if (n == 9) fb0 = 0;
            n++;
            @(negedge clk_100);
        end
        check("t1_count", 32'(n), 32'd11);
        check("t1_state", 32'(dut0.r_state), 32'd1);
        check("t1_sel",   32'(sel0), 32'd1);

        // Wrap of the data counter: 2 WRITE + 1 drain = 3 writes
        @(negedge clk_100);
        force dut0.r_data_cnt = 32'hFFFF_FFFE;
        #1 release dut0.r_data_cnt;
        fb0 = 1;
        for (int k = 0; k < 20 && slwr0; k++) @(negedge clk_100);
        check("t4_start", 32'(slwr0), 32'd0);
        n = 0; exp_d = 32'hFFFF_FFFE;
        while (!slwr0 && n < 40) begin
            check($sformatf("t4_d%0d", n), d0, exp_d);
            exp_d++;
            if (n == 1) fb0 = 0;
            n++;
            @(negedge clk_100);
        end
        check("t4_count", 32'(n), 32'd3);

        // Mode dropped mid-WRITE: data held across bursts, then cleared in IDLE
        fb0 = 1;
        for (int k = 0; k < 20 && slwr0; k++) @(negedge clk_100);
        check("t5_held", d0, 32'd1);
        m0 = 0;
        @(negedge clk_100);
        check("t5_slwr",  32'(slwr0), 32'd1);
        check("t5_state", 32'(dut0.r_state), 32'd0);
        check("t5_sel",   32'(sel0), 32'd0);
        @(negedge clk_100);
        check("t5_clear", d0, 32'd0);

        // Short packet of 4 words with PKTEND on the last
        m1 = 1; fa1 = 1; fb1 = 1;
        for (int k = 0; k < 20 && slwr1; k++) @(negedge clk_100);
        check("t2_start", 32'(slwr1), 32'd0);
        n = 0;
        while (!slwr1 && n < 40) begin
            check($sformatf("t2_d%0d", n), d1, 32'(n));
            check($sformatf("t2_pk%0d", n), 32'(pkt1), (n == 3) ? 32'd0 : 32'd1);
            n++;
            @(negedge clk_100);
        end
        check("t2_count", 32'(n), 32'd4);
        check("t2_state", 32'(dut1.r_state), 32'd1);
        check("t2_pkhi",  32'(pkt1), 32'd1);
        for (int k = 0; k < 20 && slwr1; k++) @(negedge clk_100);
        check("t2_next", d1, 32'd4);
        m1 = 0;

        // Three drain writes after 5 WRITE cycles
        m2 = 1; fa2 = 1; fb2 = 1;
        for (int k = 0; k < 20 && slwr2; k++) @(negedge clk_100);
        check("t3_start", 32'(slwr2), 32'd0);
        n = 0;
        while (!slwr2 && n < 40) begin
            check($sformatf("t3_d%0d", n), d2, 32'(n));
            if (n == 4) fb2 = 0;
            n++;
            @(negedge clk_100);
        end
        check("t3_count", 32'(n), 32'd8);
        check("t3_state", 32'(dut2.r_state), 32'd1);
        m2 = 0;

        // Asynchronous reset in the middle of a burst
        m0 = 1; fa0 = 1; fb0 = 1;
        for (int k = 0; k < 20 && slwr0; k++) @(negedge clk_100);
        check("t6_start", 32'(slwr0), 32'd0);
        @(negedge clk_100);
        @(negedge clk_100);
        #2 reset_ = 1'b0;
        #1;
        check("t6_slwr",   32'(slwr0), 32'd1);
        check("t6_pktend", 32'(pkt0),  32'd1);
        check("t6_sel",    32'(sel0),  32'd0);
        check("t6_data",   d0,         32'd0);
        @(negedge clk_100);
        reset_ = 1'b1;
        for (int k = 0; k < 20 && slwr0; k++) @(negedge clk_100);
        check("t6_restart", 32'(slwr0), 32'd0);
        check("t6_first",   d0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
